// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and default sizing for the UART transmit arbiter.
package uart_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  localparam int NREQ_DEF    = 4;
  localparam int DATA_W_DEF  = 8;
  localparam int TIMEOUT_DEF = 64;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester lanes plus the single transmitter handshake, bundled for the arbiter.
interface uart_tx_arbiter_if
  import uart_pkg::*;
#(
  parameter int NREQ   = NREQ_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  localparam int IDX_W = $clog2(NREQ);

  logic [NREQ-1:0]             req;
  logic [NREQ-1:0][DATA_W-1:0] data;
  logic [NREQ-1:0]             last;
  logic [NREQ-1:0]             ack;
  logic                        tx_valid;
  logic [DATA_W-1:0]           tx_data;
  logic                        tx_ready;
  logic [IDX_W-1:0]            owner;
  logic                        busy;

  modport master (
    output req, data, last, tx_ready,
    input  ack, tx_valid, tx_data, owner, busy
  );

  modport slave (
    input  req, data, last, tx_ready,
    output ack, tx_valid, tx_data, owner, busy
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin selector: first asserted request at or after rr_ptr, wrapping.
module rr_pick
  import uart_pkg::*;
#(
  parameter  int NREQ  = NREQ_DEF,
  localparam int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [IDX_W-1:0] index,
  output logic             any_valid
);

  // Walk from the farthest candidate back to rr_ptr so the nearest hit is written last.
  always_comb begin
    int lane_s;
    lane_s    = 0;
    index     = {IDX_W{1'b0}};
    any_valid = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      lane_s = int'(rr_ptr) + i;
      if (lane_s >= NREQ) begin
        lane_s = lane_s - NREQ;
      end else begin
        lane_s = lane_s;
      end
      if (req[lane_s]) begin
        index     = IDX_W'(lane_s);
        any_valid = 1'b1;
      end else begin
        any_valid = any_valid;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-locking round-robin arbiter feeding one UART transmitter from NREQ byte sources.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NREQ    = NREQ_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input logic              clock,
  input logic              nreset,
  uart_tx_arbiter_if.slave bus
);

  localparam int IDX_W = $clog2(NREQ);
  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] STALL_LIMIT = CNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NREQ - 1);

  state_t           state_r;
  logic [IDX_W-1:0] owner_r;
  logic [IDX_W-1:0] rr_ptr_r;
  logic [CNT_W-1:0] stall_r;
  logic [IDX_W-1:0] pick_s;
  logic [IDX_W-1:0] next_ptr_s;
  logic             any_s;
  logic             own_req_s;
  logic             own_last_s;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req       (bus.req),
    .rr_ptr    (rr_ptr_r),
    .index     (pick_s),
    .any_valid (any_s)
  );

  assign own_req_s  = bus.req[owner_r];
  assign own_last_s = bus.last[owner_r];
  assign next_ptr_s = (owner_r == LAST_IDX) ? {IDX_W{1'b0}} : owner_r + IDX_W'(1);

  // Owner's lane is passed straight through while locked so the byte is offered with no added latency.
  always_comb begin
    bus.tx_valid = 1'b0;
    bus.tx_data  = {DATA_W{1'b0}};
    bus.ack      = {NREQ{1'b0}};
    if (state_r == LOCK) begin
      bus.tx_valid     = own_req_s;
      bus.tx_data      = bus.data[owner_r];
      bus.ack[owner_r] = own_req_s & bus.tx_ready;
    end else begin
      bus.tx_valid = 1'b0;
      bus.tx_data  = {DATA_W{1'b0}};
      bus.ack      = {NREQ{1'b0}};
    end
  end

  assign bus.owner = owner_r;
  assign bus.busy  = (state_r == LOCK);

  // Arbitration FSM, round-robin pointer and owner stall counter.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_r  <= IDLE;
      owner_r  <= {IDX_W{1'b0}};
      rr_ptr_r <= {IDX_W{1'b0}};
      stall_r  <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (any_s) begin
            owner_r <= pick_s;
            stall_r <= {CNT_W{1'b0}};
            state_r <= LOCK;
          end else begin
            state_r <= IDLE;
          end
        end
        LOCK: begin
          if (own_req_s) begin
            // Back-pressure keeps req high, so it never counts toward the timeout.
            stall_r <= {CNT_W{1'b0}};
            if (bus.tx_ready && own_last_s) begin
              state_r  <= IDLE;
              rr_ptr_r <= next_ptr_s;
            end else begin
              state_r <= LOCK;
            end
          end else if (stall_r == STALL_LIMIT) begin
            stall_r  <= {CNT_W{1'b0}};
            state_r  <= IDLE;
            rr_ptr_r <= next_ptr_s;
          end else begin
            stall_r <= stall_r + CNT_W'(1);
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
